// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, step count and FSM states for the sequential 8x8 multiplier front end
package mult_pkg;
  localparam int WIDTH  = 8;
  localparam int DIGIT  = 2;
  localparam int STEPS  = WIDTH / DIGIT;
  localparam int PROD_W = 2 * WIDTH;
  localparam int K_W    = $clog2(STEPS);
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/pp_digit_mult.sv
// pp_digit_mult: unsigned WIDTH x DIGIT multiply, shifted left by DIGIT*step
module pp_digit_mult
  import mult_pkg::*;
(
  input  logic [WIDTH-1:0]  a,
  input  logic [DIGIT-1:0]  digit,
  input  logic [K_W-1:0]    step,
  output logic [PROD_W-1:0] pp
);
  logic [WIDTH+DIGIT-1:0] prod;
  assign prod = a * digit;
  assign pp = {{(PROD_W-WIDTH-DIGIT){1'b0}}, prod} << (DIGIT * step);
endmodule

// File: rtl/pp_sequencer_8_bit.sv
// pp_sequencer_8_bit: issues four shifted partial products per 8x8 multiply, framed by pp_first/pp_last
// Optional consumer back-pressure via pp_ready when PP_STALL_EN is defined.
module pp_sequencer_8_bit
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
`ifdef PP_STALL_EN
  input  logic              pp_ready,
`endif
  output logic              ready,
  output logic [PROD_W-1:0] pp,
  output logic              pp_valid,
  output logic              pp_first,
  output logic              pp_last,
  output logic              busy
);
  localparam logic [K_W-1:0] K_LAST = K_W'(STEPS - 1);
  state_t state, state_n;
  logic [K_W-1:0] k, k_n, sel_k;
  logic [WIDTH-1:0] a_reg, b_reg, a_n, b_n, sel_a, sel_b;
  logic [PROD_W-1:0] pp_n, term;
  logic valid_n, first_n, last_n, advance, accept, last_step;
  assign last_step = k == K_LAST;
`ifdef PP_STALL_EN
  assign advance = pp_ready;
  assign ready   = state == IDLE;
`else
  assign advance = 1'b1;
  assign ready   = (state == IDLE) | (state == ISSUE & last_step & advance);
`endif
  assign accept = start & ready;
  assign busy   = state == ISSUE;
  // the registered term is computed one step ahead: from the inputs on accept, else from k+1
  assign sel_k = accept ? '0 : k + K_W'(1);
  assign sel_a = accept ? a : a_reg;
  assign sel_b = accept ? b : b_reg;
  pp_digit_mult u_mult (
    .a(sel_a),
    .digit(sel_b[DIGIT*sel_k +: DIGIT]),
    .step(sel_k),
    .pp(term)
  );
  always_comb begin
    state_n = state;
    k_n     = k;
    a_n     = a_reg;
    b_n     = b_reg;
    pp_n    = pp;
    valid_n = pp_valid;
    first_n = pp_first;
    last_n  = pp_last;
    if (accept) begin
      state_n = ISSUE;
      k_n     = '0;
      a_n     = a;
      b_n     = b;
      pp_n    = term;
      valid_n = 1'b1;
      first_n = 1'b1;
      last_n  = K_LAST == '0;
    end else if (state == ISSUE && advance) begin
      state_n = last_step ? IDLE : ISSUE;
      k_n     = last_step ? '0 : sel_k;
      pp_n    = last_step ? '0 : term;
      valid_n = ~last_step;
      first_n = 1'b0;
      last_n  = ~last_step & (sel_k == K_LAST);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      pp       <= '0;
      pp_valid <= 1'b0;
      pp_first <= 1'b0;
      pp_last  <= 1'b0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      a_reg    <= a_n;
      b_reg    <= b_n;
      pp       <= pp_n;
      pp_valid <= valid_n;
      pp_first <= first_n;
      pp_last  <= last_n;
    end
  end
endmodule

// File: tb/tb_pp_sequencer_8_bit.sv
// tb_pp_sequencer_8_bit: directed self-checking bench for pp_sequencer_8_bit (PP_STALL_EN optional)
module tb_pp_sequencer_8_bit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic pp_ready = 1'b1;
  logic ready, pp_valid, pp_first, pp_last, busy;
  logic [15:0] pp, sum;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pp_sequencer_8_bit dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef PP_STALL_EN
    .pp_ready(pp_ready),
`endif
    .ready(ready), .pp(pp), .pp_valid(pp_valid), .pp_first(pp_first),
    .pp_last(pp_last), .busy(busy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic term(input string tag, input logic [15:0] e_pp, input logic e_first, input logic e_last);
    chk({tag, " pp"}, {16'h0, pp}, {16'h0, e_pp});
    chk({tag, " frame"}, {29'h0, pp_valid, pp_first, pp_last}, {29'h0, 1'b1, e_first, e_last});
    sum = sum + pp;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, " idle"}, {27'h0, pp_valid, pp_first, pp_last, busy, ready}, 32'h1);
    chk({tag, " pp0"}, {16'h0, pp}, 32'h0);
  endtask
  task automatic go(input logic [7:0] ai, input logic [7:0] bi);
    a = ai; b = bi; start = 1'b1; sum = '0;
    step();
    start = 1'b0; a = 8'h5A; b = 8'hC3;
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    idle_chk("reset");
    go(8'hFF, 8'hFF);
    term("ffff t0", 16'h02FD, 1, 0);
    chk("ffff busy", {31'h0, busy}, 32'h1);
    step(); term("ffff t1", 16'h0BF4, 0, 0);
    step(); term("ffff t2", 16'h2FD0, 0, 0);
    step(); term("ffff t3", 16'hBF40, 0, 1);
    chk("ffff sum", {16'h0, sum}, 32'hFE01);
    step(); idle_chk("ffff end");
    go(8'h12, 8'h34);
    term("1234 t0", 16'h0000, 1, 0);
    step(); term("1234 t1", 16'h0048, 0, 0);
    step(); term("1234 t2", 16'h0360, 0, 0);
    step(); term("1234 t3", 16'h0000, 0, 1);
    chk("1234 sum", {16'h0, sum}, 32'h03A8);
    step(); idle_chk("1234 end");
    go(8'h00, 8'hFF);
    term("zero t0", 16'h0, 1, 0);
    step(); term("zero t1", 16'h0, 0, 0);
    step(); term("zero t2", 16'h0, 0, 0);
    step(); term("zero t3", 16'h0, 0, 1);
    step(); idle_chk("zero end");
`ifndef PP_STALL_EN
    a = 8'h03; b = 8'h05; start = 1'b1; sum = '0;
    step(); term("b2b a t0", 16'h0003, 1, 0);
    chk("b2b ready mid", {31'h0, ready}, 32'h0);
    step(); term("b2b a t1", 16'h000C, 0, 0);
    step(); term("b2b a t2", 16'h0000, 0, 0);
    step(); term("b2b a t3", 16'h0000, 0, 1);
    chk("b2b a sum", {16'h0, sum}, 32'd15);
    chk("b2b ready last", {31'h0, ready}, 32'h1);
    a = 8'h07; b = 8'h09; sum = '0;
    step(); start = 1'b0; a = 8'h00; b = 8'h00;
    term("b2b b t0", 16'h0007, 1, 0);
    step(); term("b2b b t1", 16'h0038, 0, 0);
    step(); term("b2b b t2", 16'h0000, 0, 0);
    step(); term("b2b b t3", 16'h0000, 0, 1);
    chk("b2b b sum", {16'h0, sum}, 32'd63);
    step(); idle_chk("b2b end");
`endif
    go(8'hFF, 8'hFF);
    term("ign t0", 16'h02FD, 1, 0);
    step(); term("ign t1", 16'h0BF4, 0, 0);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    chk("ign ready", {31'h0, ready}, 32'h0);
    step(); start = 1'b0;
    term("ign t2", 16'h2FD0, 0, 0);
    step(); term("ign t3", 16'hBF40, 0, 1);
    chk("ign sum", {16'h0, sum}, 32'hFE01);
    step(); idle_chk("ign end");
    go(8'hFF, 8'hFF);
    step();
    step(); term("rst t2", 16'h2FD0, 0, 0);
    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34;
    step(); rst = 1'b0; start = 1'b0;
    idle_chk("rst abort");
    step(); idle_chk("rst drop start");
    go(8'h12, 8'h34);
    term("post t0", 16'h0000, 1, 0);
    step(); term("post t1", 16'h0048, 0, 0);
    step(); term("post t2", 16'h0360, 0, 0);
    step(); term("post t3", 16'h0000, 0, 1);
    step(); idle_chk("post end");
`ifdef PP_STALL_EN
    go(8'hFF, 8'hFF);
    term("stall t0", 16'h02FD, 1, 0);
    step(); term("stall t1", 16'h0BF4, 0, 0);
    pp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall hold pp", {16'h0, pp}, 32'h0BF4);
      chk("stall hold frame", {30'h0, pp_valid, pp_last}, 32'h2);
    end
    pp_ready = 1'b1;
    step(); term("stall t2", 16'h2FD0, 0, 0);
    step(); term("stall t3", 16'hBF40, 0, 1);
    chk("stall ready last", {31'h0, ready}, 32'h0);
    step(); idle_chk("stall end");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
